aftab_dawu_burst: RTL and testbench

Parametrised successor of the AFTAB data adjustment write unit (DAWU). Takes a 1–4 byte store from the datapath and writes it to memory as one or more beats, each MEM_BYTES wide with per-lane byte enables. Steers bytes onto the correct lanes, splits stores that cross a beat boundary, and performs the optional misalignment check. Sits between the AFTAB datapath/controller and the data memory port.

---
 rtl/aftab_dawu_burst_if.sv | 45 ++++
 rtl/aftab_dawu_burst.sv | 175 +++++++++++++++++
 tb/tb_aftab_dawu_burst.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aftab_dawu_burst_if.sv
// Store-side bus of the AFTAB burst data adjustment write unit.
// The datapath/memory environment uses the master modport, the DAWU uses slave.
// The memErr/storeAccessFault pair exists only when AFTAB_DAWU_MEMERR_EN is defined.
interface aftab_dawu_burst_if #(
    parameter int XLEN      = 32,
    parameter int MEM_BYTES = 1
);
    logic [XLEN-1:0]        addrIn;
    logic [XLEN-1:0]        dataIn;
    logic [1:0]             nBytes;
    logic                   startDAWU;
    logic                   memReady;
    logic                   checkMisalignedDAWU;
    logic [XLEN-1:0]        addrOut;
    logic [8*MEM_BYTES-1:0] dataOut;
    logic [MEM_BYTES-1:0]   byteEn;
    logic                   writeMem;
    logic                   completeDAWU;
    logic                   storeMisalignedFlag;
    logic                   busyDAWU;
`ifdef AFTAB_DAWU_MEMERR_EN
    logic                   memErr;
    logic                   storeAccessFault;
`endif

    modport master (
`ifdef AFTAB_DAWU_MEMERR_EN
        output memErr,
        input  storeAccessFault,
`endif
        output addrIn, dataIn, nBytes, startDAWU, memReady, checkMisalignedDAWU,
        input  addrOut, dataOut, byteEn, writeMem, completeDAWU,
        input  storeMisalignedFlag, busyDAWU
    );

    modport slave (
`ifdef AFTAB_DAWU_MEMERR_EN
        input  memErr,
        output storeAccessFault,
`endif
        input  addrIn, dataIn, nBytes, startDAWU, memReady, checkMisalignedDAWU,
        output addrOut, dataOut, byteEn, writeMem, completeDAWU,
        output storeMisalignedFlag, busyDAWU
    );
endinterface

// File: rtl/aftab_dawu_burst.sv
// AFTAB burst data adjustment write unit: turns a 1..4 byte store into one or
// more MEM_BYTES-wide beats with lane-placed data and byte enables, splitting
// stores that straddle a beat boundary and flagging misaligned stores.
// Optional memory error abort: define AFTAB_DAWU_MEMERR_EN.
module aftab_dawu_burst #(
    parameter int XLEN      = 32,
    parameter int MEM_BYTES = 1     // 1, 2 or 4
) (
    input  logic              clk,
    input  logic              rst,
    aftab_dawu_burst_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE, S_MISAL} state_t;

    localparam logic [XLEN-1:0] BASE_MASK = ~XLEN'(MEM_BYTES - 1);
    localparam logic [1:0]      LANE_MASK = 2'(MEM_BYTES - 1);

    state_t                 state_q;
    logic [XLEN-1:0]        addr_out_q;
    logic [8*MEM_BYTES-1:0] data_out_q;
    logic [MEM_BYTES-1:0]   byte_en_q;
    logic                   write_q, complete_q, misal_q, busy_q;
`ifdef AFTAB_DAWU_MEMERR_EN
    logic                   fault_q;
`endif

    // Cursor: address of the next unwritten byte, the unwritten bytes
    // (next one in bits [7:0]) and how many of them remain.
    logic [XLEN-1:0]        cur_addr_q, cur_data_q;
    logic [2:0]             cur_rem_q;

    logic [XLEN-1:0]        cur_addr, cur_data, lane_data;
    logic [2:0]             cur_rem;
    logic [XLEN-1:0]        beat_base_d, nxt_addr_d, nxt_data_d;
    logic [8*MEM_BYTES-1:0] beat_data_d;
    logic [MEM_BYTES-1:0]   beat_be_d;
    logic [2:0]             nxt_rem_d;
    logic                   misaligned;
    int                     lane_i, rem_i, taken;

    // Beat source: the incoming request while idle, the cursor while writing.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_addr = bus.addrIn;
            cur_data = bus.dataIn;
            cur_rem  = {1'b0, bus.nBytes} + 3'd1;
        end else begin
            cur_addr = cur_addr_q;
            cur_data = cur_data_q;
            cur_rem  = cur_rem_q;
        end
    end

    // Build the beat holding the next byte: lanes from its lane up to the end
    // of the beat or the end of the store, whichever comes first.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional update, otherwise synthesis infers latches.
        beat_be_d   = '0;
        beat_data_d = '0;
        taken       = 0;
        beat_base_d = cur_addr & BASE_MASK;
        lane_i      = int'(cur_addr[1:0] & LANE_MASK);
        rem_i       = int'(cur_rem);
        lane_data   = cur_data << (8 * lane_i);
        for (int l = 0; l < MEM_BYTES; l++) begin
            if (l >= lane_i && (l - lane_i) < rem_i) begin
                beat_be_d[l]         = 1'b1;
                beat_data_d[8*l +: 8] = lane_data[8*l +: 8];
                taken                = taken + 1;
            end
        end
        nxt_addr_d = beat_base_d + XLEN'(MEM_BYTES);
        nxt_data_d = cur_data >> (8 * taken);
        nxt_rem_d  = cur_rem - 3'(taken);
    end

    // Misalignment only matters for halfword and word stores.
    always_comb begin
        misaligned = bus.checkMisalignedDAWU &&
                     ((bus.nBytes == 2'd1 && bus.addrIn[0]) ||
                      (bus.nBytes == 2'd3 && bus.addrIn[1:0] != 2'b00));
    end

    // Control FSM with registered beat and strobe outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_out_q <= '0;
            data_out_q <= '0;
            byte_en_q  <= '0;
            write_q    <= 1'b0;
            complete_q <= 1'b0;
            misal_q    <= 1'b0;
            busy_q     <= 1'b0;
            cur_addr_q <= '0;
            cur_data_q <= '0;
            cur_rem_q  <= '0;
`ifdef AFTAB_DAWU_MEMERR_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            complete_q <= 1'b0;
            misal_q    <= 1'b0;
`ifdef AFTAB_DAWU_MEMERR_EN
            fault_q    <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (bus.startDAWU) begin
                        busy_q <= 1'b1;
                        if (misaligned) begin
                            state_q    <= S_MISAL;
                            misal_q    <= 1'b1;
                            complete_q <= 1'b1;
                        end else begin
                            state_q    <= S_WRITE;
                            write_q    <= 1'b1;
                            addr_out_q <= beat_base_d;
                            data_out_q <= beat_data_d;
                            byte_en_q  <= beat_be_d;
                            cur_addr_q <= nxt_addr_d;
                            cur_data_q <= nxt_data_d;
                            cur_rem_q  <= nxt_rem_d;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.memReady) begin
`ifdef AFTAB_DAWU_MEMERR_EN
                        if (bus.memErr) begin
                            state_q    <= S_DONE;
                            write_q    <= 1'b0;
                            complete_q <= 1'b1;
                            fault_q    <= 1'b1;
                        end else
`endif
                        if (cur_rem_q != 3'd0) begin
                            addr_out_q <= beat_base_d;
                            data_out_q <= beat_data_d;
                            byte_en_q  <= beat_be_d;
                            cur_addr_q <= nxt_addr_d;
                            cur_data_q <= nxt_data_d;
                            cur_rem_q  <= nxt_rem_d;
                        end else begin
                            state_q    <= S_DONE;
                            write_q    <= 1'b0;
                            complete_q <= 1'b1;
                        end
                    end
                end
                S_DONE, S_MISAL: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.addrOut             = addr_out_q;
    assign bus.dataOut             = data_out_q;
    assign bus.byteEn              = byte_en_q;
    assign bus.writeMem            = write_q;
    assign bus.completeDAWU        = complete_q;
    assign bus.storeMisalignedFlag = misal_q;
    assign bus.busyDAWU            = busy_q;
`ifdef AFTAB_DAWU_MEMERR_EN
    assign bus.storeAccessFault    = fault_q;
`endif

endmodule

// File: tb/tb_aftab_dawu_burst.sv
// Bench for aftab_dawu_burst: three instances (MEM_BYTES = 1, 2, 4) share a
// clock and reset; expected beats are queued when a store is issued and
// popped as the memory side accepts them.
module tb_aftab_dawu_burst;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } beat_t;

    logic clk, rst;

    logic [31:0] addr_in [3], data_in [3];
    logic [1:0]  n_bytes [3];
    logic        start [3], mem_ready [3], chk_mis [3], mem_err [3];
    logic [31:0] addr_out [3], data_out [3];
    logic [3:0]  byte_en [3];
    logic        write_mem [3], complete [3], misal [3], busy [3], fault [3];

    int n_total, n_bad;
    int n_done [3], n_misal [3], n_fault [3], beats_acc [3];
    bit done_due [3], fault_due [3];
    beat_t sb [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int MB = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        aftab_dawu_burst_if #(.XLEN(32), .MEM_BYTES(MB)) bus ();
        assign bus.addrIn              = addr_in[g];
        assign bus.dataIn              = data_in[g];
        assign bus.nBytes              = n_bytes[g];
        assign bus.startDAWU           = start[g];
        assign bus.memReady            = mem_ready[g];
        assign bus.checkMisalignedDAWU = chk_mis[g];
        assign addr_out[g]             = bus.addrOut;
        assign data_out[g]             = 32'(bus.dataOut);
        assign byte_en[g]              = 4'(bus.byteEn);
        assign write_mem[g]            = bus.writeMem;
        assign complete[g]             = bus.completeDAWU;
        assign misal[g]                = bus.storeMisalignedFlag;
        assign busy[g]                 = bus.busyDAWU;
`ifdef AFTAB_DAWU_MEMERR_EN
        assign bus.memErr              = mem_err[g];
        assign fault[g]                = bus.storeAccessFault;
`else
        assign fault[g]                = 1'b0;
`endif
        aftab_dawu_burst #(.XLEN(32), .MEM_BYTES(MB)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mb_of(input int idx);
        return (idx == 0) ? 1 : (idx == 1) ? 2 : 4;
    endfunction

    // Reference byte walk: byte i lands at address a+i, lane (a+i) mod mb.
    function automatic void push_beats(input int mb, input logic [31:0] a,
                                       input logic [31:0] d, input int len);
        beat_t       b;
        logic [31:0] ba, base;
        int          lane;
        bit          open;
        open = 1'b0;
        b.addr = '0; b.data = '0; b.be = '0;
        for (int i = 0; i < len; i++) begin
            ba   = a + 32'(i);
            lane = int'(ba % 32'(mb));
            base = ba - 32'(lane);
            if (!open || base != b.addr) begin
                if (open) sb.push_back(b);
                b.addr = base; b.data = '0; b.be = '0;
                open = 1'b1;
            end
            b.data[8*lane +: 8] = d[8*i +: 8];
            b.be[lane]          = 1'b1;
        end
        if (open) sb.push_back(b);
    endfunction

    // Memory-side monitor: every write cycle must show the head beat.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (done_due[i]) begin
                    check("done_latency", 32'(complete[i]), 32'd1);
                    done_due[i] = 1'b0;
                end
                if (fault_due[i]) begin
                    check("fault_pulse", 32'(fault[i]), 32'd1);
                    fault_due[i] = 1'b0;
                end
                if (write_mem[i]) begin
                    if (sb.size() == 0) begin
                        check("extra_beat", 32'(write_mem[i]), 32'd0);
                    end else begin
                        check("beat_addr", addr_out[i], sb[0].addr);
                        check("beat_data", data_out[i], sb[0].data);
                        check("beat_be", 32'(byte_en[i]), 32'(sb[0].be));
                        if (mem_ready[i]) begin
                            void'(sb.pop_front());
                            beats_acc[i]++;
                            if (mem_err[i]) begin
                                sb.delete();
                                fault_due[i] = 1'b1;
                            end
                            if (sb.size() == 0) done_due[i] = 1'b1;
                        end
                    end
                end
                if (complete[i]) n_done[i]++;
                if (misal[i])    n_misal[i]++;
                if (fault[i])    n_fault[i]++;
            end
        end
    end

    function automatic logic ready_fn(input int pattern, input int c);
        case (pattern)
            1:       return (c % 4) == 3;
            2:       return c >= 10;
            default: return 1'b1;
        endcase
    endfunction

    // Issue one store and follow it to completion.
    // pattern: 0 ready always, 1 ready every 4th cycle, 2 stall 10 then ready.
    // ghost: pulse startDAWU mid-stall. err_beat: beat index carrying memErr.
    task automatic run_store(input int idx, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] nb, input logic chk, input int pattern,
                             input bit ghost, input int err_beat);
        bit exp_mis;
        int done0, mis0, flt0, acc0, exp_beats, c;
        exp_mis = chk && ((nb == 2'd1 && a[0]) || (nb == 2'd3 && a[1:0] != 2'b00));
        if (!exp_mis) push_beats(mb_of(idx), a, d, int'(nb) + 1);
        exp_beats = (err_beat >= 0 && !exp_mis) ? err_beat + 1 : sb.size();
        done0 = n_done[idx]; mis0 = n_misal[idx]; flt0 = n_fault[idx]; acc0 = beats_acc[idx];

        @(posedge clk); #1;
        addr_in[idx] = a; data_in[idx] = d; n_bytes[idx] = nb; chk_mis[idx] = chk;
        start[idx] = 1'b1;
        mem_ready[idx] = (pattern == 0);
        mem_err[idx] = (err_beat == 0);
        @(posedge clk); #1;
        start[idx] = 1'b0;
        @(negedge clk);
        check("busy_after_start", 32'(busy[idx]), 32'd1);
        if (exp_mis) begin
            check("misal_pulse", 32'(misal[idx]), 32'd1);
            check("misal_complete", 32'(complete[idx]), 32'd1);
            check("misal_no_write", 32'(write_mem[idx]), 32'd0);
            @(negedge clk);
            check("misal_one_cycle", 32'(misal[idx]), 32'd0);
            check("misal_complete_one_cycle", 32'(complete[idx]), 32'd0);
        end else begin
            check("write_latency", 32'(write_mem[idx]), 32'd1);
        end
        #1;
        c = 0;
        while (n_done[idx] == done0 && c < 300) begin
            mem_ready[idx] = ready_fn(pattern, c);
            mem_err[idx]   = (err_beat >= 0) && (beats_acc[idx] - acc0 == err_beat);
            if (ghost && c == 4) begin
                addr_in[idx] = a + 32'h100; start[idx] = 1'b1;
            end else begin
                start[idx] = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        if (c >= 300) check("timeout", 32'd0, 32'd1);
        mem_ready[idx] = 1'b0; mem_err[idx] = 1'b0; start[idx] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("complete_count", 32'(n_done[idx] - done0), 32'd1);
        check("misal_count", 32'(n_misal[idx] - mis0), 32'(exp_mis));
        check("fault_count", 32'(n_fault[idx] - flt0), (err_beat >= 0 && !exp_mis) ? 32'd1 : 32'd0);
        check("beats_accepted", 32'(beats_acc[idx] - acc0), 32'(exp_beats));
        check("queue_drained", 32'(sb.size()), 32'd0);
        check("idle_busy", 32'(busy[idx]), 32'd0);
        check("idle_write", 32'(write_mem[idx]), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_addr"}, addr_out[i], 32'd0);
            check({tag, "_data"}, data_out[i], 32'd0);
            check({tag, "_be"}, 32'(byte_en[i]), 32'd0);
            check({tag, "_write"}, 32'(write_mem[i]), 32'd0);
            check({tag, "_complete"}, 32'(complete[i]), 32'd0);
            check({tag, "_misal"}, 32'(misal[i]), 32'd0);
            check({tag, "_busy"}, 32'(busy[i]), 32'd0);
            check({tag, "_fault"}, 32'(fault[i]), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done0, c;
        n_total = 0; n_bad = 0;
        for (int i = 0; i < 3; i++) begin
            addr_in[i] = '0; data_in[i] = '0; n_bytes[i] = '0; start[i] = 1'b0;
            mem_ready[i] = 1'b0; chk_mis[i] = 1'b0; mem_err[i] = 1'b0;
            n_done[i] = 0; n_misal[i] = 0; n_fault[i] = 0; beats_acc[i] = 0;
            done_due[i] = 1'b0; fault_due[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Word store, one byte per beat, slow memory.
        run_store(0, 32'h0300FF55, 32'hAA00FF0F, 2'd3, 1'b0, 1, 1'b0, -1);
        // Halfword straddling a 4-byte beat boundary.
        run_store(2, 32'h00001003, 32'h12345678, 2'd1, 1'b0, 0, 1'b0, -1);
        // Misaligned word with checking enabled: no beat at all.
        run_store(2, 32'h00002002, 32'h0BADF00D, 2'd3, 1'b1, 0, 1'b0, -1);
        // Byte store stalled for 10 cycles with a start pulse during the stall.
        run_store(1, 32'h00000010, 32'h000000CC, 2'd0, 1'b0, 2, 1'b1, -1);
        // Aligned word with checking on, 3-byte straddle, misaligned half, wraps.
        run_store(2, 32'h00000040, 32'h89ABCDEF, 2'd3, 1'b1, 0, 1'b0, -1);
        run_store(1, 32'h00000033, 32'h00112233, 2'd2, 1'b1, 1, 1'b0, -1);
        run_store(1, 32'h00000021, 32'h00005A5A, 2'd1, 1'b1, 0, 1'b0, -1);
        run_store(2, 32'hFFFFFFFE, 32'hA1B2C3D4, 2'd3, 1'b0, 0, 1'b0, -1);
        run_store(0, 32'hFFFFFFFF, 32'h0000BEEF, 2'd1, 1'b0, 0, 1'b0, -1);

        // Reset in the middle of a word store after two accepted beats.
        push_beats(1, 32'h00000080, 32'hDEADBEEF, 4);
        done0 = n_done[0];
        @(posedge clk); #1;
        addr_in[0] = 32'h00000080; data_in[0] = 32'hDEADBEEF; n_bytes[0] = 2'd3;
        chk_mis[0] = 1'b0; start[0] = 1'b1; mem_ready[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        c = 0;
        while (beats_acc[0] < 2 + (beats_acc[0] - beats_acc[0]) && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        c = 0;
        while (sb.size() > 2 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= 50) check("reset_wait_timeout", 32'd0, 32'd1);
        rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        sb.delete();
        mem_ready[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("no_complete_after_reset", 32'(n_done[0] - done0), 32'd0);
        run_store(0, 32'h00000090, 32'h01020304, 2'd3, 1'b0, 0, 1'b0, -1);

`ifdef AFTAB_DAWU_MEMERR_EN
        // Memory error on the second beat aborts the rest of the word.
        run_store(0, 32'h000000A0, 32'h11223344, 2'd3, 1'b0, 0, 1'b0, 1);
`endif

        // Random mix across all three lane widths.
        for (int k = 0; k < 12; k++) begin
            run_store(int'($urandom_range(2, 0)), $urandom, $urandom,
                      2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                      int'($urandom_range(1, 0)), 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
